// File: rtl/chirp_pkg.sv
// chirp_pkg
// Shared definitions for the DDS chirp sequencer: default datapath widths,
// the default start-frequency and sweep-step words, and the sequencer
// state encoding. Plain localparam state constants keep the encoding
// usable from older tool flows that do not handle enums well.
package chirp_pkg;

  localparam int N_DEF        = 32;
  localparam int FRAC_DEF     = 32;
  localparam int W_DEF        = N_DEF + FRAC_DEF;
  localparam int CNT_BITS_DEF = 20;

  // Default chirp words in accumulator format (integer.fraction).
  localparam logic [63:0] FTW0_DEF  = 64'h000008637BD05AF7;
  localparam logic [63:0] DELTA_DEF = 64'h00000000001ABD79;

  // Sequencer state encoding.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_SWEEP = 3'd2;
  localparam state_t S_GAP   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/chirp_cfg_regs.sv
// chirp_cfg_regs
// Shadow/active register pair for the chirp configuration. The host writes
// the shadow set at any time; the active set only changes on i_copy, so a
// burst in progress always sees a stable configuration.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_we               load i_ftw0..i_count into the shadow set
//   i_ftw0..i_count    new configuration values
//   i_copy             transfer shadow to active this cycle
//   o_shadow_len       shadow length (checked before a burst is accepted)
//   o_ftw0..o_count    active configuration
module chirp_cfg_regs
  import chirp_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [W-1:0]        i_ftw0,
  input  logic [W-1:0]        i_delta,
  input  logic [CNT_BITS-1:0] i_len,
  input  logic [CNT_BITS-1:0] i_gap,
  input  logic [15:0]         i_count,
  input  logic                i_copy,
  output logic [CNT_BITS-1:0] o_shadow_len,
  output logic [W-1:0]        o_ftw0,
  output logic [W-1:0]        o_delta,
  output logic [CNT_BITS-1:0] o_len,
  output logic [CNT_BITS-1:0] o_gap,
  output logic [15:0]         o_count
);

  logic [W-1:0]        r_sh_ftw0;
  logic [W-1:0]        r_sh_delta;
  logic [CNT_BITS-1:0] r_sh_len;
  logic [CNT_BITS-1:0] r_sh_gap;
  logic [15:0]         r_sh_count;

  logic [W-1:0]        r_ftw0;
  logic [W-1:0]        r_delta;
  logic [CNT_BITS-1:0] r_len;
  logic [CNT_BITS-1:0] r_gap;
  logic [15:0]         r_count;

  // Shadow set: host-visible configuration, writable in any state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_ftw0  <= {W{1'b0}};
      r_sh_delta <= {W{1'b0}};
      r_sh_len   <= {CNT_BITS{1'b0}};
      r_sh_gap   <= {CNT_BITS{1'b0}};
      r_sh_count <= 16'd0;
    end else if (i_we) begin
      r_sh_ftw0  <= i_ftw0;
      r_sh_delta <= i_delta;
      r_sh_len   <= i_len;
      r_sh_gap   <= i_gap;
      r_sh_count <= i_count;
    end else begin
      r_sh_ftw0  <= r_sh_ftw0;
      r_sh_delta <= r_sh_delta;
      r_sh_len   <= r_sh_len;
      r_sh_gap   <= r_sh_gap;
      r_sh_count <= r_sh_count;
    end
  end

  // Active set: copies the shadow (pre-write value) when a burst is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ftw0  <= {W{1'b0}};
      r_delta <= {W{1'b0}};
      r_len   <= {CNT_BITS{1'b0}};
      r_gap   <= {CNT_BITS{1'b0}};
      r_count <= 16'd0;
    end else if (i_copy) begin
      r_ftw0  <= r_sh_ftw0;
      r_delta <= r_sh_delta;
      r_len   <= r_sh_len;
      r_gap   <= r_sh_gap;
      r_count <= r_sh_count;
    end else begin
      r_ftw0  <= r_ftw0;
      r_delta <= r_delta;
      r_len   <= r_len;
      r_gap   <= r_gap;
      r_count <= r_count;
    end
  end

  assign o_shadow_len = r_sh_len;
  assign o_ftw0       = r_ftw0;
  assign o_delta      = r_delta;
  assign o_len        = r_len;
  assign o_gap        = r_gap;
  assign o_count      = r_count;

endmodule

// File: rtl/chirp_sequencer.sv
// chirp_sequencer
// Run-time controller for the DDS chirp datapath. On an accepted start it
// issues a burst of linear chirps: each chirp is one reload cycle
// (o_acc_load) followed by cfg_len gated samples (o_dds_en) and cfg_gap idle
// samples. All outputs are registered.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_cfg_we, i_cfg_*       shadow configuration write
//   i_start                 begin a burst (acted on only in IDLE)
//   i_abort                 stop the burst at once, no done pulse
//   o_busy, o_done, o_err   burst status / completion / rejected start
//   o_acc_load              reload strobe for the frequency accumulator
//   o_ftw0_acc, o_delta_acc active start word and step
//   o_dds_en                DAC sample-valid gate
//   o_chirp_idx             current chirp index, 0-based
module chirp_sequencer
  import chirp_pkg::*;
#(
  parameter  int N        = N_DEF,
  parameter  int FRAC     = FRAC_DEF,
  localparam int W        = N + FRAC,
  parameter  int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_we,
  input  logic [W-1:0]        i_cfg_ftw0,
  input  logic [W-1:0]        i_cfg_delta,
  input  logic [CNT_BITS-1:0] i_cfg_len,
  input  logic [CNT_BITS-1:0] i_cfg_gap,
  input  logic [15:0]         i_cfg_count,
  input  logic                i_start,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic                o_acc_load,
  output logic [W-1:0]        o_ftw0_acc,
  output logic [W-1:0]        o_delta_acc,
  output logic                o_dds_en,
  output logic [15:0]         o_chirp_idx
);

  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic [15:0]         r_chirp_idx;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_acc_load;
  logic                r_dds_en;

  state_t              w_next_state;
  logic [CNT_BITS-1:0] w_next_cnt;
  logic [15:0]         w_next_idx;
  logic                w_copy;
  logic                w_err;
  logic                w_more;
  logic [CNT_BITS-1:0] w_shadow_len;
  logic [CNT_BITS-1:0] w_act_len;
  logic [CNT_BITS-1:0] w_act_gap;
  logic [15:0]         w_act_count;

  chirp_cfg_regs #(
    .W        (W),
    .CNT_BITS (CNT_BITS)
  ) u_cfg (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_we         (i_cfg_we),
    .i_ftw0       (i_cfg_ftw0),
    .i_delta      (i_cfg_delta),
    .i_len        (i_cfg_len),
    .i_gap        (i_cfg_gap),
    .i_count      (i_cfg_count),
    .i_copy       (w_copy),
    .o_shadow_len (w_shadow_len),
    .o_ftw0       (o_ftw0_acc),
    .o_delta      (o_delta_acc),
    .o_len        (w_act_len),
    .o_gap        (w_act_gap),
    .o_count      (w_act_count)
  );

  // Next-state, counter and chirp-index logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_idx   = r_chirp_idx;
    w_copy       = 1'b0;
    w_err        = 1'b0;
    // Another chirp follows when running continuously or below the count;
    // the 17-bit compare keeps idx+1 from wrapping at 0xFFFF.
    w_more = (w_act_count == 16'd0) ||
             (({1'b0, r_chirp_idx} + 17'd1) < {1'b0, w_act_count});

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_shadow_len != CNT_ZERO) begin
            w_copy       = 1'b1;
            w_next_idx   = 16'd0;
            w_next_state = S_LOAD;
          end else begin
            w_err = 1'b1;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD: begin
        w_next_cnt   = CNT_ZERO;
        w_next_state = S_SWEEP;
      end
      S_SWEEP: begin
        if (r_cnt == (w_act_len - CNT_ONE)) begin
          w_next_cnt = CNT_ZERO;
          if (w_act_gap != CNT_ZERO) begin
            w_next_state = S_GAP;
          end else if (w_more) begin
            w_next_idx   = r_chirp_idx + 16'd1;
            w_next_state = S_LOAD;
          end else begin
            w_next_state = S_DONE;
          end
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        if (r_cnt == (w_act_gap - CNT_ONE)) begin
          w_next_cnt = CNT_ZERO;
          if (w_more) begin
            w_next_idx   = r_chirp_idx + 16'd1;
            w_next_state = S_LOAD;
          end else begin
            w_next_state = S_DONE;
          end
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Abort outranks every transition, but does nothing from IDLE.
    if (i_abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      w_next_cnt   = CNT_ZERO;
      w_next_idx   = r_chirp_idx;
      w_copy       = 1'b0;
      w_err        = 1'b0;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_chirp_idx <= 16'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_acc_load  <= 1'b0;
      r_dds_en    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_chirp_idx <= w_next_idx;
      r_busy      <= (w_next_state != S_IDLE);
      r_done      <= (w_next_state == S_DONE);
      r_err       <= w_err;
      r_acc_load  <= (w_next_state == S_LOAD);
      r_dds_en    <= (w_next_state == S_SWEEP);
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_acc_load  = r_acc_load;
  assign o_dds_en    = r_dds_en;
  assign o_chirp_idx = r_chirp_idx;

endmodule
